// File: rtl/cpu_pipe_pkg.sv
// Shared CPU pipeline constants: bubble instruction, decode field bit positions, opcode encodings.
package cpu_pipe_pkg;

  localparam int unsigned BASE_INSTR_W = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'hF000_0000;

  localparam int unsigned OPC_HI   = 31;
  localparam int unsigned OPC_LO   = 26;
  localparam int unsigned RS_HI    = 25;
  localparam int unsigned RS_LO    = 21;
  localparam int unsigned RT_HI    = 20;
  localparam int unsigned RT_LO    = 16;
  localparam int unsigned RD_HI    = 15;
  localparam int unsigned RD_LO    = 11;
  localparam int unsigned SHAMT_HI = 10;
  localparam int unsigned SHAMT_LO = 6;
  localparam int unsigned FUNCT_HI = 5;
  localparam int unsigned FUNCT_LO = 0;
  localparam int unsigned IMM16_HI = 15;
  localparam int unsigned IMM26_HI = 25;

  typedef enum logic [5:0] {
    OP_SPECIAL = 6'h00,
    OP_J       = 6'h02,
    OP_JAL     = 6'h03,
    OP_BEQ     = 6'h04,
    OP_BNE     = 6'h05,
    OP_ADDI    = 6'h08,
    OP_LW      = 6'h23,
    OP_SW      = 6'h2B
  } opcode_e;

endpackage

// File: rtl/ifid_skid_fifo.sv
// Two-entry storage for the IF/ID skid buffer: entries, wrapping pointers and occupancy.
module ifid_skid_fifo #(
  parameter int unsigned W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push, do_pop;

  // Flush wins over both push and pop; full/empty guard keeps the count in 0..2.
  assign do_push = push_i && (count_q != 2'd2) && !flush_i;
  assign do_pop  = pop_i  && (count_q != 2'd0) && !flush_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push) wr_ptr_d = ~wr_ptr_q;
      if (do_pop)  rd_ptr_d = ~rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ifid_skid_reg.sv
// IF/ID pipeline register as a 2-entry skid buffer with bubble insertion.
// Define IFID_DECODE_EN to add the sliced decode-field outputs.
module ifid_skid_reg
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          PC_W      = 32,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  output logic               in_ready,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               out_ready,
`ifdef IFID_DECODE_EN
  input  logic               flush,
  output logic [5:0]         opcode,
  output logic [4:0]         rs,
  output logic [4:0]         rt,
  output logic [4:0]         rd,
  output logic [4:0]         shamt,
  output logic [5:0]         funct,
  output logic [15:0]        imm16,
  output logic [25:0]        imm26
`else
  input  logic               flush
`endif
);

  localparam int unsigned ENTRY_W = INSTR_W + PC_W;

  logic [ENTRY_W-1:0] head;
  logic [1:0]         count;
  logic               push, pop;

  // Ready depends only on held state plus the flush/reset overrides, never on out_ready.
  assign in_ready  = !rst && !flush && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  ifid_skid_fifo #(
    .W(ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .wdata_i ({in_instr, in_pc}),
    .rdata_o (head),
    .count_o (count)
  );

  assign out_instr = out_valid ? head[ENTRY_W-1:PC_W] : NOP_INSTR;
  assign out_pc    = out_valid ? head[PC_W-1:0]       : '0;

`ifdef IFID_DECODE_EN
  assign opcode = out_instr[OPC_HI:OPC_LO];
  assign rs     = out_instr[RS_HI:RS_LO];
  assign rt     = out_instr[RT_HI:RT_LO];
  assign rd     = out_instr[RD_HI:RD_LO];
  assign shamt  = out_instr[SHAMT_HI:SHAMT_LO];
  assign funct  = out_instr[FUNCT_HI:FUNCT_LO];
  assign imm16  = out_instr[IMM16_HI:0];
  assign imm26  = out_instr[IMM26_HI:0];
`endif

endmodule
